// File: rtl/sample_seq_pkg.sv
// Shared types, default offsets and the 10-bit saturation helper for the sample sequencer.
package sample_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCALE,
    ST_OUTPUT
  } state_e;

  localparam logic [9:0] ADC_OFFSET_DEF = 10'h181;
  localparam logic [9:0] DAC_OFFSET_DEF = 10'h200;

  typedef struct packed {
    logic       clip;
    logic [9:0] val;
  } sat10_t;

  // Clamp a 13-bit signed value into the 10-bit two's complement range.
  function automatic sat10_t sat10(input logic signed [12:0] v);
    sat10_t r;
    if (v > 13'sd511) begin
      r.clip = 1'b1;
      r.val  = 10'h1FF;
    end else if (v < -13'sd512) begin
      r.clip = 1'b1;
      r.val  = 10'h200;
    end else begin
      r.clip = 1'b0;
      r.val  = v[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_timer.sv
// Sample-period divider: counts 0..DIV-1, tick is high while the count is DIV-1.
// No latency beyond the count register; free-running, no backpressure.
module sample_timer #(
  parameter int unsigned DIV = 1000
) (
  input  logic sysclk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sample_sequencer.sv
// One ADC sample per period: offset removal, 2^g gain with saturation, DAC re-bias; data_out valid 2 cycles after tick.
// Holds data_out/dac_valid while dac_ready is low; ticks arriving outside IDLE are dropped and counted.
module sample_sequencer
  import sample_seq_pkg::*;
#(
  parameter logic [9:0]  ADC_OFFSET = ADC_OFFSET_DEF,
  parameter logic [9:0]  DAC_OFFSET = DAC_OFFSET_DEF,
  parameter int unsigned DIV        = 1000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [9:0] data_in,
  input  logic [1:0] gain_sel,
  input  logic       gain_we,
  input  logic       dac_ready,
  output logic [9:0] data_out,
  output logic       dac_valid,
  output logic       sample_tick,
  output logic       clip,
  output logic [7:0] overrun_cnt
);

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [1:0]  gain_act_q, gain_act_d;
  logic [1:0]  gain_pend_q, gain_pend_d;
  logic [9:0]  dout_q, dout_d;
  logic        clip_q, clip_d;
  logic        vld_q, vld_d;
  logic [7:0]  ovr_q, ovr_d;
  logic        tick;

  logic signed [12:0] scaled;
  sat10_t             sat;

  sample_timer #(.DIV(DIV)) u_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .tick   (tick)
  );

  assign scaled = $signed({{3{x_q[9]}}, x_q}) <<< gain_act_q;
  assign sat    = sat10(scaled);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    gain_act_d  = gain_act_q;
    gain_pend_d = gain_we ? gain_sel : gain_pend_q;
    dout_d      = dout_q;
    clip_d      = clip_q;
    vld_d       = vld_q;
    ovr_d       = ovr_q;

    // A tick landing while busy (including the OUTPUT->IDLE edge) is a lost sample.
    if (tick && (state_q != ST_IDLE) && (ovr_q != 8'hFF)) begin
      ovr_d = ovr_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          x_d        = data_in - ADC_OFFSET;
          gain_act_d = gain_pend_q;
          state_d    = ST_SCALE;
        end
      end
      ST_SCALE: begin
        dout_d  = sat.val + DAC_OFFSET;
        clip_d  = sat.clip;
        vld_d   = 1'b1;
        state_d = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (dac_ready) begin
          vld_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      gain_act_q  <= '0;
      gain_pend_q <= '0;
      dout_q      <= DAC_OFFSET;
      clip_q      <= 1'b0;
      vld_q       <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      gain_act_q  <= gain_act_d;
      gain_pend_q <= gain_pend_d;
      dout_q      <= dout_d;
      clip_q      <= clip_d;
      vld_q       <= vld_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out    = dout_q;
  assign dac_valid   = vld_q;
  assign sample_tick = tick;
  assign clip        = clip_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: doc/sample_sequencer.md
# sample_sequencer

Sample-rate controller for the ADC→processing→DAC path. Divides `sysclk` down to a sample strobe, captures one ADC word per strobe, removes the ADC offset, applies a run-time selectable power-of-two gain with saturation, re-biases for the DAC and hands the word to the DAC interface over a valid/ready handshake. Sits between the ADC input register and the DAC driver, replacing free-running per-clock processing with sequenced, one-sample-per-period operation.

## Interface
- `ADC_OFFSET`, 10'h181, ADC zero code; subtracted from the input.
- `DAC_OFFSET`, 10'h200, DAC zero code; added to the output.
- `DIV`, 1000, `sysclk` cycles per sample period; legal range 4..65535.
- `sysclk` in 1: system clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `data_in` in 10: raw ADC word, offset-binary.
- `gain_sel` in 2: requested gain shift g, giving gain 2^g (x1, x2, x4, x8).
- `gain_we` in 1: write strobe for `gain_sel`.
- `dac_ready` in 1: DAC accepts `data_out` when high with `dac_valid`.
- `data_out` out 10: DAC word, offset-binary.
- `dac_valid` out 1: `data_out` holds a new sample.
- `sample_tick` out 1: one-cycle strobe at the start of each sample period.
- `clip` out 1: last emitted sample was saturated.
- `overrun_cnt` out 8: count of dropped sample periods; saturates at 255.

## Operation
- Divider counts 0..DIV-1 and wraps; `sample_tick`=1 while the count is DIV-1.
- Gain is double-buffered:
  - `gain_we` loads `gain_pend` from `gain_sel`.
  - `gain_act` loads from `gain_pend` only on the capture edge.
  - A `gain_we` on the same edge as a capture affects the next sample, not this one.
- FSM states: IDLE, SCALE, OUTPUT.
  - IDLE & tick: capture `data_in` into `x_reg`, load `gain_act`, go to SCALE.
  - SCALE: compute and register the result into `data_out` and `clip`, set `dac_valid`=1, go to OUTPUT.
  - OUTPUT & `dac_ready`: clear `dac_valid`, go to IDLE.
  - OUTPUT & !`dac_ready`: hold `data_out` and `dac_valid`.
- Arithmetic:
  - x = (`data_in` − ADC_OFFSET) mod 1024, treated as 10-bit two's complement.
  - x is sign-extended to 13 bits and shifted left by g.
  - The result is clamped to [−512, 511]. `clip`=1 if clamping occurred.
  - `data_out` = (clamped + DAC_OFFSET) mod 1024.
- Overrun: a tick while the FSM is not in IDLE drops that sample and increments `overrun_cnt` (saturating at 255). The FSM is undisturbed.
- Between samples, `data_out` holds the last emitted value.

## Timing
- Reset values:
  - `data_out`=DAC_OFFSET (10'h200), `dac_valid`=0, `sample_tick`=0, `clip`=0, `overrun_cnt`=0.
  - Divider=0; `gain_pend`=`gain_act`=0; state IDLE.
- After reset deassertion, the first tick occurs DIV cycles later.
- Latency:
  - Tick in cycle T is captured at the end of T.
  - `data_out` and `dac_valid` are valid in cycle T+2.
- Handshake:
  - Transfer occurs on any edge with `dac_valid`&`dac_ready`.
  - `dac_valid` drops the cycle after the transfer.
  - `dac_ready` may be held high permanently; minimum occupancy is then 3 cycles per sample.
- Since DIV≥4, overrun is possible only through DAC backpressure.
- Tick on the same edge the FSM returns to IDLE (OUTPUT & `dac_ready`): counts as overrun. The sample is dropped.
- Reset mid-operation: state returns to IDLE in one edge, `dac_valid` drops, and no partial sample is emitted.

## Structure
- Package `sample_seq_pkg` holds:
  - FSM state enum.
  - Default ADC_OFFSET/DAC_OFFSET constants.
  - `sat10` function: 13-bit signed in, 10-bit signed out plus clip flag.
- Sub-module `sample_timer`: parameter DIV; ports `sysclk`, `reset`, `tick`. Contains the divider only.
- The top level holds the FSM, gain registers, datapath and overrun counter.

## Test plan
- DIV=8, g=0, `data_in`=10'h181, `dac_ready`=1 → `data_out`=10'h200, `clip`=0, `dac_valid` pulses 2 cycles after each tick.
- g=2, `data_in`=10'h191 (x=16) → scaled 64, `data_out`=10'h240.
- g=1, `data_in`=10'h2FF (x=382) → 764 clamps to 511, `data_out`=10'h3FF, `clip`=1. `data_in`=10'h000 (x=−385) → clamps to −512, `data_out`=10'h000, `clip`=1.
- `gain_we` with `gain_sel`=3 on the capture edge → that sample uses the old g; the following sample uses g=3.
- `dac_ready`=0 for 3·DIV cycles → `overrun_cnt`=2 or 3 per tick timing, `data_out`/`dac_valid` stable throughout. After ready rises, one transfer completes, then normal cadence resumes. 300 forced overruns → `overrun_cnt` stuck at 255.
- `reset` pulsed during OUTPUT → next cycle `dac_valid`=0, `data_out`=10'h200, state IDLE, first tick DIV cycles after release.
